// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, bus widths,
// PC step and the default reset PC.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential PC, wrapping modulo 2^32.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request bus: req/addr out, ready/data back in the same cycle.
// The fetch controller is the master; the memory is the slave.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic               imemReq;
  logic [ADDR_W-1:0]  imemAddr;
  logic               imemReady;
  logic [INSTR_W-1:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemData
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry {instr, pc} buffer: head slot drives decode, skid absorbs one word
// that returns while the head is stalled. Registered outputs, flush keeps head data.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_dat,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);

  fetch_entry_t skid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      valid  <= 1'b0;
      skid_q <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      // Head contents stay visible on instrF/PCF; only the valid bits drop.
      valid <= 1'b0;
      full  <= 1'b0;
    end else if (pop && full) begin
      head  <= skid_q;
      valid <= 1'b1;
      full  <= push;
      if (push) begin
        skid_q <= push_dat;
      end
    end else if (push && (!valid || pop)) begin
      head  <= push_dat;
      valid <= 1'b1;
    end else if (push) begin
      skid_q <= push_dat;
      full   <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the fetch PC, requests words from imem and hands one
// instruction per cycle to decode; 1-cycle fetch latency at zero wait, redirect costs one bubble.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hazardDetected,
  input  logic                PCSrcD,
  input  logic [ADDR_W-1:0]   PCbranchD,
  fetch_controller_if.master  imem,
  output logic [INSTR_W-1:0]  instrF,
  output logic [ADDR_W-1:0]   PCF,
  output logic                validF
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] redirect_target;

  logic         consume;
  logic         redirect;
  logic         req;
  logic         buf_push;
  logic         buf_flush;
  logic         buf_valid;
  logic         buf_full;
  fetch_entry_t buf_in;
  fetch_entry_t buf_head;

  assign consume         = buf_valid && !hazardDetected;
  assign redirect        = PCSrcD && !hazardDetected;
  assign redirect_target = align_pc(PCbranchD);

  assign buf_in.instr = imem.imemData;
  assign buf_in.pc    = pc_q;

  // DRAIN keeps presenting the old pc, so the address is always pc_q.
  assign imem.imemReq  = req;
  assign imem.imemAddr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    req       = 1'b0;
    buf_push  = 1'b0;
    buf_flush = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        req = 1'b1;
        if (redirect) begin
          buf_flush = 1'b1;
          if (imem.imemReady) begin
            pc_d = redirect_target;
          end else begin
            // The memory still owns the old request; finish it before retargeting.
            target_d = redirect_target;
            state_d  = ST_DRAIN;
          end
        end else if (imem.imemReady) begin
          buf_push = 1'b1;
          pc_d     = next_pc(pc_q);
          if (buf_full || (buf_valid && !consume)) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          buf_flush = 1'b1;
          pc_d      = redirect_target;
          state_d   = ST_REQ;
        end else if (consume) begin
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        req       = 1'b1;
        buf_flush = redirect;
        if (redirect) begin
          target_d = redirect_target;
        end
        if (imem.imemReady) begin
          pc_d    = redirect ? redirect_target : target_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (buf_push),
    .pop      (consume),
    .flush    (buf_flush),
    .push_dat (buf_in),
    .head     (buf_head),
    .valid    (buf_valid),
    .full     (buf_full)
  );

  assign instrF = buf_head.instr;
  assign PCF    = buf_head.pc;
  assign validF = buf_valid;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, a stall/release sequence and
// a randomized run scored against an instruction-stream model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazardDetected;
  logic        PCSrcD;
  logic [31:0] PCbranchD;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic        validF;

  fetch_controller_if imem_if ();

  // Memory returns an address-tagged word.
  assign imem_if.imemData = ~imem_if.imemAddr;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(32'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazardDetected (hazardDetected),
    .PCSrcD         (PCSrcD),
    .PCbranchD      (PCbranchD),
    .imem           (imem_if),
    .instrF         (instrF),
    .PCF            (PCF),
    .validF         (validF)
  );

  typedef struct {
    logic        rst_n;
    logic        haz;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(input logic r, input logic h, input logic p,
                              input logic [31:0] t, input logic rd,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc,
                              input logic instr_zero);
    vec_t v;
    v.rst_n   = r;
    v.haz     = h;
    v.pcsrc   = p;
    v.tgt     = t;
    v.rdy     = rd;
    v.e_req   = e_req;
    v.e_addr  = e_addr;
    v.e_vld   = e_vld;
    v.e_pc    = e_pc;
    v.e_instr = instr_zero ? 32'd0 : ~e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic p,
                       input logic [31:0] t, input logic rd);
    rst_n             = r;
    hazardDetected    = h;
    PCSrcD            = p;
    PCbranchD         = t;
    imem_if.imemReady = rd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_wait;
    logic        h, p, rd;
    logic [31:0] t;
    int          consumed;

    n_pass  = 0;
    n_total = 0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Row: drive inputs | outputs expected in the same cycle (before the edge).
    //                     rst haz pcs tgt            rdy  req addr           vld pc             zero
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h4,         1, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h8,         1, 32'h4,         0));
    vecs.push_back(mk(1, 0, 1, 32'h100,       1,   1, 32'hC,         1, 32'h8,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h8,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1,   1, 32'h104,       1, 32'h100,       0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1,   0, 32'h108,       1, 32'h100,       0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1,   0, 32'h108,       1, 32'h100,       0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1,   0, 32'h108,       1, 32'h100,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   0, 32'h108,       1, 32'h100,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h108,       1, 32'h104,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0,   1, 32'h10C,       1, 32'h108,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0,   1, 32'h10C,       0, 32'h108,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0,   1, 32'h10C,       0, 32'h108,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h10C,       0, 32'h108,       0));
    vecs.push_back(mk(1, 0, 1, 32'h200,       0,   1, 32'h110,       1, 32'h10C,       0));
    vecs.push_back(mk(1, 0, 1, 32'h300,       0,   1, 32'h110,       0, 32'h10C,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0,   1, 32'h110,       0, 32'h10C,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h110,       0, 32'h10C,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h300,       0, 32'h10C,       0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1,   1, 32'h304,       1, 32'h300,       0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,   0, 32'h308,       1, 32'h300,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 1,   1, 32'h4,         1, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 1, 32'h400,       0,   1, 32'h0,         1, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(1, 0, 1, 32'h503,       1,   1, 32'h0,         0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h500,       0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(1, 1, 1, 32'h700,       1,   1, 32'h504,       1, 32'h500,       0));
    vecs.push_back(mk(1, 0, 1, 32'h800,       1,   0, 32'h508,       1, 32'h500,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h800,       0, 32'h500,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,   1, 32'h804,       1, 32'h800,       0));

    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("vec%0d_req", i),   32'(imem_if.imemReq), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d_addr", i),  imem_if.imemAddr,     vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(validF),          32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_pcf", i),   PCF,                  vecs[i].e_pc);
      chk($sformatf("vec%0d_instr", i), instrF,               vecs[i].e_instr);
      drive(vecs[i].rst_n, vecs[i].haz, vecs[i].pcsrc, vecs[i].tgt, vecs[i].rdy);
      step();
    end

    // Long stall with slot and skid full, then release: stream resumes gap-free.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (3) step();
    chk("stall_start_pcf", PCF, 32'h4);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_req", k), 32'(imem_if.imemReq), 32'd0);
      chk($sformatf("stall%0d_pcf", k), PCF, 32'h4);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("release%0d_pcf", k),   PCF, 32'(4 + 4 * k));
      chk($sformatf("release%0d_valid", k), 32'(validF), 32'd1);
      step();
    end

    // Randomized run: delivered stream must follow program order and redirects.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    exp_pc    = 32'd0;
    prev_wait = 1'b0;
    prev_addr = 32'd0;
    consumed  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (validF) begin
        chk("rnd_data", instrF, ~PCF);
      end
      if (prev_wait) begin
        chk("rnd_addr_hold", imem_if.imemAddr, prev_addr);
        chk("rnd_req_hold", 32'(imem_if.imemReq), 32'd1);
      end
      h  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) != 0);
      p  = (c >= 2) && ($urandom_range(0, 15) == 0);
      t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
      drive(1'b1, h, p, t, rd);
      if (p && !h) begin
        exp_pc = t & ~32'd3;
      end else if (validF && !h) begin
        chk("rnd_pc_order", PCF, exp_pc);
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      prev_wait = imem_if.imemReq && !rd;
      prev_addr = imem_if.imemAddr;
      step();
    end
    chk("rnd_progress", 32'(consumed > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
